// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared sizes, beat layout and state encoding for the CPU state dumper
package cpu_dbg_pkg;
    localparam int DATA_W         = 32;
    localparam int NUM_REGS       = 32;
    localparam int NUM_DMEM_WORDS = 8;
    localparam int HDR_BEATS      = 4;
    localparam int DUMP_BEATS     = HDR_BEATS + NUM_REGS + NUM_DMEM_WORDS;
    localparam int REG_BASE       = HDR_BEATS;
    localparam int MEM_BASE       = HDR_BEATS + NUM_REGS;

    typedef enum logic [1:0] {IDLE, HDR, REG, MEM} dump_state_e;
endpackage

// File: rtl/dbg_event_counter.sv
// rtl/dbg_event_counter.sv - free-running wrapping event counter
module dbg_event_counter
    import cpu_dbg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    output logic [DATA_W-1:0] count_o
);
    logic [DATA_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) count_d = count_q + DATA_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/cpu_state_dumper.sv
// rtl/cpu_state_dumper.sv - counts cycles/stalls/flushes and streams a header, RF and low DMEM on request
module cpu_state_dumper
    import cpu_dbg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              dump_req_i,
    output logic              busy_o,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic              dmem_rd_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    input  logic [DATA_W-1:0] dmem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [7:0]        out_index_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);
    localparam logic [7:0] BEATS_N  = 8'(DUMP_BEATS);
    localparam logic [7:0] LAST_IDX = 8'(DUMP_BEATS - 1);
    localparam logic [7:0] REG_IDX  = 8'(REG_BASE);
    localparam logic [7:0] MEM_IDX  = 8'(MEM_BASE);

    logic [DATA_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

    dbg_event_counter u_cycle_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(1'b1),    .count_o(cycle_cnt));
    dbg_event_counter u_stall_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(stall_i), .count_o(stall_cnt));
    dbg_event_counter u_flush_cnt (.clk_i(clk_i), .rst_i(rst_i), .inc_i(flush_i), .count_o(flush_cnt));

    dump_state_e       state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [DATA_W-1:0] snap_stall_q, snap_stall_d, snap_flush_q, snap_flush_d;
    logic [DATA_W-1:0] snap_cycle_q, snap_cycle_d, snap_pc_q, snap_pc_d;
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [7:0]        out_index_q, out_index_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              load_en, loading;
    logic [DATA_W-1:0] beat_data;
    logic [4:0]        reg_off;
    logic [2:0]        mem_off;

    // idx_q is the index of the next beat to be loaded into the output register
    assign load_en = !out_valid_q || out_ready_i;
    assign loading = (state_q != IDLE) && (idx_q < BEATS_N) && load_en;
    assign reg_off = idx_q[4:0] - REG_IDX[4:0];
    assign mem_off = idx_q[2:0] - MEM_IDX[2:0];

    always_comb begin
        beat_data = '0;
        case (state_q)
            HDR: begin
                case (idx_q[1:0])
                    2'd0:    beat_data = snap_cycle_q;
                    2'd1:    beat_data = snap_stall_q;
                    2'd2:    beat_data = snap_flush_q;
                    default: beat_data = snap_pc_q;
                endcase
            end
            REG:     beat_data = reg_data_i;
            MEM:     beat_data = dmem_data_i;
            default: beat_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_cycle_d = snap_cycle_q;
        snap_stall_d = snap_stall_q;
        snap_flush_d = snap_flush_q;
        snap_pc_d    = snap_pc_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_index_d  = out_index_q;
        out_data_d   = out_data_q;
        if (state_q == IDLE) begin
            // beat 0 is loaded straight from the live counter on the accept edge
            if (dump_req_i) begin
                state_d      = HDR;
                idx_d        = 8'd1;
                snap_cycle_d = cycle_cnt;
                snap_stall_d = stall_cnt;
                snap_flush_d = flush_cnt;
                snap_pc_d    = pc_i;
                out_valid_d  = 1'b1;
                out_last_d   = 1'b0;
                out_index_d  = 8'd0;
                out_data_d   = cycle_cnt;
            end
        end else if (idx_q < BEATS_N) begin
            if (load_en) begin
                out_valid_d = 1'b1;
                out_data_d  = beat_data;
                out_index_d = idx_q;
                out_last_d  = (idx_q == LAST_IDX);
                idx_d       = idx_q + 8'd1;
                if (idx_d >= MEM_IDX)      state_d = MEM;
                else if (idx_d >= REG_IDX) state_d = REG;
                else                       state_d = HDR;
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            snap_cycle_q <= '0;
            snap_stall_q <= '0;
            snap_flush_q <= '0;
            snap_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_index_q  <= '0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_cycle_q <= snap_cycle_d;
            snap_stall_q <= snap_stall_d;
            snap_flush_q <= snap_flush_d;
            snap_pc_q    <= snap_pc_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_index_q  <= out_index_d;
            out_data_q   <= out_data_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign reg_addr_o  = (state_q == REG) ? reg_off : 5'd0;
    assign dmem_rd_o   = loading && (state_q == MEM);
    assign dmem_addr_o = dmem_rd_o ? DATA_W'({mem_off, 2'b00}) : '0;
    assign out_valid_o = out_valid_q;
    assign out_index_o = out_index_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
endmodule
